// File: rtl/br_fifo_push_ctrl_core_pkg.sv
// Shared width helpers for the FIFO push control core.
package br_fifo_push_ctrl_core_pkg;

    // clog2 that never collapses to zero bits, so one-entry structures keep a real port.
    function automatic int clamped_clog2(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/br_fifo_push_ctrl_core_counter.sv
// Wrapping up-counter: value advances by incr_i on incr_valid_i and wraps past MaxValue to 0.
module br_fifo_push_ctrl_core_counter
    import br_fifo_push_ctrl_core_pkg::*;
#(
    parameter int MaxValue = 1,
    parameter int MaxIncrement = 1,
    localparam int ValueWidth = clamped_clog2(MaxValue + 1),
    localparam int IncrWidth = clamped_clog2(MaxIncrement + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  incr_valid_i,
    input  logic [IncrWidth-1:0]  incr_i,
    output logic [ValueWidth-1:0] value_o
);

    localparam int SumWidth = ValueWidth + IncrWidth;

    if (MaxValue == 0) begin : g_tied
        logic unused_inputs;
        assign unused_inputs = ^{clk, rst_n, incr_valid_i, incr_i};
        assign value_o = '0;
    end else begin : g_count
        logic [ValueWidth-1:0] value_q, value_d;
        logic [SumWidth-1:0]   sum;

        always_comb begin
            sum = SumWidth'(value_q) + SumWidth'(incr_i);
            value_d = value_q;
            if (incr_valid_i) begin
                value_d = (sum > SumWidth'(MaxValue)) ? ValueWidth'(sum - SumWidth'(MaxValue + 1))
                                                      : ValueWidth'(sum);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) value_q <= '0;
            else        value_q <= value_d;
        end

        assign value_o = value_q;
    end

endmodule

// File: rtl/br_fifo_push_ctrl_core.sv
// FIFO push controller: routes beats to the bypass path or RAM write port and owns occupancy.
module br_fifo_push_ctrl_core
    import br_fifo_push_ctrl_core_pkg::*;
#(
    parameter int Depth = 2,
    parameter int Width = 1,
    parameter int EnableBypass = 1,
    parameter int RamDepth = Depth,
    parameter int RegisterWriteOutputs = 0,
    parameter int EnableAssertFinalNotValid = 1,
    localparam int AddrWidth = clamped_clog2(RamDepth),
    localparam int CountWidth = $clog2(Depth + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  push_ready,
    input  logic                  push_valid,
    input  logic [Width-1:0]      push_data,
    input  logic                  bypass_ready,
    output logic                  bypass_valid_unstable,
    output logic [Width-1:0]      bypass_data_unstable,
    output logic                  ram_wr_valid,
    output logic [AddrWidth-1:0]  ram_wr_addr,
    output logic [Width-1:0]      ram_wr_data,
    input  logic                  pop_beat,
    output logic                  empty,
    output logic [CountWidth-1:0] items,
    output logic [CountWidth-1:0] slots,
    output logic                  full
);

    logic push_beat, bypass_beat, wr_beat, pop_ram;
    logic commit, inflight, inflight_d;
    logic push_ready_q, push_ready_d;
    logic [CountWidth-1:0] items_q, items_d, slots_d;

    assign push_beat             = push_valid && push_ready_q;
    assign bypass_valid_unstable = (EnableBypass != 0) && push_beat && (items_q == '0) && !inflight;
    assign bypass_data_unstable  = push_data;
    assign bypass_beat           = bypass_valid_unstable && bypass_ready;
    assign wr_beat               = push_beat && !bypass_beat;
    // Bypass pops were never counted in, so only RAM-side pops drain items.
    assign pop_ram               = pop_beat && !bypass_beat;

    if (RegisterWriteOutputs != 0) begin : g_reg_wr
        logic             wr_valid_q;
        logic [Width-1:0] wr_data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_valid_q <= 1'b0;
                wr_data_q  <= '0;
            end else begin
                wr_valid_q <= wr_beat;
                if (wr_beat) wr_data_q <= push_data;
            end
        end

        // A registered write holds a slot but is not readable until it lands in RAM.
        assign ram_wr_valid = wr_valid_q;
        assign ram_wr_data  = wr_data_q;
        assign inflight     = wr_valid_q;
        assign commit       = wr_valid_q;
        assign inflight_d   = wr_beat;
    end else begin : g_comb_wr
        assign ram_wr_valid = wr_beat;
        assign ram_wr_data  = push_data;
        assign inflight     = 1'b0;
        assign commit       = wr_beat;
        assign inflight_d   = 1'b0;
    end

    br_fifo_push_ctrl_core_counter #(
        .MaxValue    (RamDepth - 1),
        .MaxIncrement(1)
    ) u_wr_addr (
        .clk         (clk),
        .rst_n       (rst_n),
        .incr_valid_i(ram_wr_valid),
        .incr_i      (1'b1),
        .value_o     (ram_wr_addr)
    );

    always_comb begin
        items_d      = items_q + CountWidth'(commit) - CountWidth'(pop_ram);
        slots_d      = CountWidth'(Depth) - items_d - CountWidth'(inflight_d);
        push_ready_d = (slots_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            items_q      <= '0;
            push_ready_q <= 1'b0;
        end else begin
            items_q      <= items_d;
            push_ready_q <= push_ready_d;
        end
    end

    assign push_ready = push_ready_q;
    assign items      = items_q;
    assign empty      = (items_q == '0);
    assign slots      = CountWidth'(Depth) - items_q - CountWidth'(inflight);
    assign full       = (slots == '0);

`ifndef SYNTHESIS
    a_push_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (push_valid && !push_ready_q) |=> (push_valid && $stable(push_data)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_beat && (items_q == '0) && !bypass_beat));
    a_items_bound: assert property (@(posedge clk) disable iff (!rst_n)
        items_q <= CountWidth'(RamDepth));
    a_bypass_ready: assert property (@(posedge clk) disable iff (!rst_n)
        !(bypass_ready && !bypass_valid_unstable));

    final begin
        if (EnableAssertFinalNotValid != 0) begin
            a_final_idle: assert (!push_valid && (items_q == '0));
        end
    end
`endif

endmodule
